// File: rtl/stack_alu_engine_pkg.sv
// Shared definitions for the stack ALU engine: opcodes, FSM states and operand-count helpers.
package stack_alu_engine_pkg;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_PUSH  = 5'd1;
  localparam logic [4:0] OP_POP   = 5'd2;
  localparam logic [4:0] OP_ADD   = 5'd3;
  localparam logic [4:0] OP_SUB   = 5'd4;
  localparam logic [4:0] OP_MUL   = 5'd5;
  localparam logic [4:0] OP_DIV   = 5'd6;
  localparam logic [4:0] OP_AND   = 5'd7;
  localparam logic [4:0] OP_NAND  = 5'd8;
  localparam logic [4:0] OP_OR    = 5'd9;
  localparam logic [4:0] OP_XOR   = 5'd10;
  localparam logic [4:0] OP_CMP   = 5'd11;
  localparam logic [4:0] OP_NOT   = 5'd12;
  localparam logic [4:0] OP_IF_EQ = 5'd13;
  localparam logic [4:0] OP_IF_GT = 5'd14;
  localparam logic [4:0] OP_IF_LT = 5'd15;
  localparam logic [4:0] OP_IF_GE = 5'd16;
  localparam logic [4:0] OP_IF_LE = 5'd17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP_A,
    ST_POP_B,
    ST_EXEC,
    ST_WB
  } state_t;

  // Illegal opcodes report zero so they never trip the underflow check.
  function automatic logic [1:0] operands_needed(input logic [4:0] op);
    if (op == OP_NOP || op == OP_PUSH || op > OP_IF_LE) return 2'd0;
    if (op == OP_POP || op == OP_NOT) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic is_if_op(input logic [4:0] op);
    return (op >= OP_IF_EQ) && (op <= OP_IF_LE);
  endfunction

endpackage

// File: rtl/stack_alu_engine_ula.sv
// Combinational ALU: unsigned arithmetic/logic results, IF_xx condition and divide-by-zero flag.
module stack_alu_ula
  import stack_alu_engine_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] result,
  output logic             cond,
  output logic             div0
);

  always_comb begin
    result = '0;
    cond   = 1'b0;
    div0   = 1'b0;
    case (op)
      OP_ADD:  result = op1 + op2;
      OP_SUB:  result = op1 - op2;
      OP_MUL:  result = op1 * op2;
      OP_DIV: begin
        // Division by zero saturates to all-ones rather than producing X.
        if (op2 == '0) begin
          result = '1;
          div0   = 1'b1;
        end else begin
          result = op1 / op2;
        end
      end
      OP_AND:  result = op1 & op2;
      OP_NAND: result = ~(op1 & op2);
      OP_OR:   result = op1 | op2;
      OP_XOR:  result = op1 ^ op2;
      OP_CMP: begin
        if (op1 == op2)     result = '0;
        else if (op1 > op2) result = {{(WIDTH-1){1'b0}}, 1'b1};
        else                result = '1;
      end
      OP_NOT:   result = ~op1;
      OP_IF_EQ: cond = (op1 == op2);
      OP_IF_GT: cond = (op1 > op2);
      OP_IF_LT: cond = (op1 < op2);
      OP_IF_GE: cond = (op1 >= op2);
      OP_IF_LE: cond = (op1 <= op2);
      default: ;
    endcase
  end

endmodule

// File: rtl/stack_alu_engine.sv
// Stack-based ALU engine: command handshake, operand stack, sequencing FSM and error pulses.
module stack_alu_engine
  import stack_alu_engine_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [4:0]               cmd_op,
  input  logic [WIDTH-1:0]         cmd_data,
  output logic [WIDTH-1:0]         tos,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     res_valid,
  output logic [WIDTH-1:0]         result,
  output logic                     cond,
  output logic                     err_ovf,
  output logic                     err_unf,
  output logic                     err_div0,
  output logic                     err_ill,
  output state_t                   dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE and a command offered while it is low is dropped, not queued.

  state_t           state;
  logic [AW-1:0]    sp;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] temp1, temp2;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] top_entry;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cond, alu_div0;
  logic             accept, cmd_legal, cmd_unf, stack_full;
  logic             idle_push, wb_push, mem_we;
  logic [WIDTH-1:0] mem_wdata;

  assign dbg_state  = state;
  assign top_entry  = mem[sp - 1'b1];
  assign tos        = (count == '0) ? '0 : top_entry;

  assign accept     = cmd_valid && cmd_ready;
  assign cmd_legal  = (cmd_op <= OP_IF_LE);
  assign cmd_unf    = (count < CW'(operands_needed(cmd_op)));
  assign stack_full = (count == FULL);

  assign idle_push  = accept && (cmd_op == OP_PUSH) && !stack_full;
  assign wb_push    = (state == ST_EXEC) && !is_if_op(op_q);
  assign mem_we     = idle_push || wb_push;
  assign mem_wdata  = wb_push ? alu_result : cmd_data;

  stack_alu_ula #(.WIDTH(WIDTH)) u_ula (
    .op     (op_q),
    .op1    (temp1),
    .op2    (temp2),
    .result (alu_result),
    .cond   (alu_cond),
    .div0   (alu_div0)
  );

  // Storage is deliberately not reset; count gates every read.
  always_ff @(posedge clk) begin
    if (mem_we) mem[sp] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      sp        <= '0;
      count     <= '0;
      temp1     <= '0;
      temp2     <= '0;
      op_q      <= OP_NOP;
      result    <= '0;
      cond      <= 1'b0;
      cmd_ready <= 1'b0;
      res_valid <= 1'b0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
      err_div0  <= 1'b0;
      err_ill   <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
      err_div0  <= 1'b0;
      err_ill   <= 1'b0;
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            op_q <= cmd_op;
            if (!cmd_legal) begin
              err_ill <= 1'b1;
            end else if (cmd_unf) begin
              err_unf <= 1'b1;
            end else begin
              case (cmd_op)
                OP_NOP: ;
                OP_PUSH: begin
                  if (stack_full) begin
                    err_ovf <= 1'b1;
                  end else begin
                    sp    <= sp + 1'b1;
                    count <= count + 1'b1;
                  end
                end
                OP_POP: begin
                  sp    <= sp - 1'b1;
                  count <= count - 1'b1;
                end
                OP_NOT: begin
                  state     <= ST_POP_A;
                  cmd_ready <= 1'b0;
                end
                default: begin
                  state     <= ST_POP_B;
                  cmd_ready <= 1'b0;
                end
              endcase
            end
          end
        end
        ST_POP_B: begin
          temp2 <= top_entry;
          sp    <= sp - 1'b1;
          count <= count - 1'b1;
          state <= ST_POP_A;
        end
        ST_POP_A: begin
          temp1 <= top_entry;
          sp    <= sp - 1'b1;
          count <= count - 1'b1;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          // Results land on the edge into WB so the WB cycle shows the completed state.
          state     <= ST_WB;
          res_valid <= 1'b1;
          if (is_if_op(op_q)) begin
            cond <= alu_cond;
          end else begin
            result   <= alu_result;
            err_div0 <= alu_div0;
            sp       <= sp + 1'b1;
            count    <= count + 1'b1;
          end
        end
        ST_WB: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_alu_engine.sv
// Bench for stack_alu_engine: directed scenarios plus random commands against a queue-based stack model.
module tb_stack_alu_engine;
  import stack_alu_engine_pkg::*;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int CW = $clog2(D) + 1;
  localparam int EW = 5 + W + 1 + CW + W + 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [4:0]    cmd_op = 5'd0;
  logic [W-1:0]  cmd_data = '0;
  logic [W-1:0]  tos;
  logic [CW-1:0] count;
  logic          res_valid;
  logic [W-1:0]  result;
  logic          cond;
  logic          err_ovf, err_unf, err_div0, err_ill;
  state_t        dbg_state;

  stack_alu_engine #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .tos       (tos),
    .count     (count),
    .res_valid (res_valid),
    .result    (result),
    .cond      (cond),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf),
    .err_div0  (err_div0),
    .err_ill   (err_ill),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // reference model state
  logic [W-1:0]  stk[$];
  logic [W-1:0]  m_result = '0;
  logic          m_cond = 1'b0;
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_miss = 0;

  function automatic logic [EW-1:0] pack(input logic ovf, input logic unf, input logic dz,
                                         input logic ill, input logic rv, input logic [W-1:0] res,
                                         input logic cnd, input logic [CW-1:0] cnt,
                                         input logic [W-1:0] t, input logic [15:0] c);
    return {ovf, unf, dz, ill, rv, res, cnd, cnt, t, c};
  endfunction

  function automatic logic [W-1:0] m_tos();
    return (stk.size() == 0) ? '0 : stk[stk.size()-1];
  endfunction

  function automatic logic [CW-1:0] m_cnt();
    return CW'(stk.size());
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Applies one command to the model and queues the output event it should produce.
  task automatic model_step(input logic [4:0] op, input logic [W-1:0] d, output int busy);
    logic [W-1:0] a, b;
    logic [15:0]  c0;
    int need;
    busy = 0;
    c0 = 16'(cyc);
    if (op == OP_NOP || op == OP_PUSH) need = 0;
    else if (op == OP_POP || op == OP_NOT) need = 1;
    else need = 2;
    if (op > 5'd17) begin
      exp_q.push_back(pack(0, 0, 0, 1, 0, m_result, m_cond, m_cnt(), m_tos(), c0 + 16'd1));
    end else if (stk.size() < need) begin
      exp_q.push_back(pack(0, 1, 0, 0, 0, m_result, m_cond, m_cnt(), m_tos(), c0 + 16'd1));
    end else if (op == OP_PUSH) begin
      if (stk.size() == D)
        exp_q.push_back(pack(1, 0, 0, 0, 0, m_result, m_cond, m_cnt(), m_tos(), c0 + 16'd1));
      else
        stk.push_back(d);
    end else if (op == OP_POP) begin
      a = stk.pop_back();
    end else if (op == OP_NOT) begin
      a = stk.pop_back();
      m_result = ~a;
      stk.push_back(m_result);
      busy = 3;
      exp_q.push_back(pack(0, 0, 0, 0, 1, m_result, m_cond, m_cnt(), m_tos(), c0 + 16'd3));
    end else if (op != OP_NOP) begin
      b = stk.pop_back();
      a = stk.pop_back();
      busy = 4;
      if (op >= OP_IF_EQ) begin
        case (op)
          OP_IF_EQ: m_cond = (a == b);
          OP_IF_GT: m_cond = (a > b);
          OP_IF_LT: m_cond = (a < b);
          OP_IF_GE: m_cond = (a >= b);
          default:  m_cond = (a <= b);
        endcase
      end else begin
        case (op)
          OP_ADD:  m_result = W'(int'(a) + int'(b));
          OP_SUB:  m_result = W'(int'(a) - int'(b));
          OP_MUL:  m_result = W'(longint'(a) * longint'(b));
          OP_DIV:  m_result = (b == 0) ? {W{1'b1}} : W'(int'(a) / int'(b));
          OP_AND:  m_result = a & b;
          OP_NAND: m_result = ~(a & b);
          OP_OR:   m_result = a | b;
          OP_XOR:  m_result = a ^ b;
          default: m_result = (a == b) ? W'(0) : (a > b) ? W'(1) : {W{1'b1}};
        endcase
        stk.push_back(m_result);
      end
      exp_q.push_back(pack(0, 0, (op == OP_DIV) && (b == 0), 0, 1, m_result, m_cond,
                           m_cnt(), m_tos(), c0 + 16'd4));
    end
  endtask

  // scoreboard monitor: every pulse cycle is matched against the head of the expected queue
  logic [EW-1:0] mon_act, mon_exp;
  always @(negedge clk) begin
    if (reset && (res_valid || err_ovf || err_unf || err_div0 || err_ill)) begin
      mon_act = pack(err_ovf, err_unf, err_div0, err_ill, res_valid, result, cond, count, tos,
                     16'(cyc));
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_event act=%h", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_miss++;
          $display("FAIL event act=%h exp=%h", mon_act, mon_exp);
        end
      end
    end
  end

  // driver tasks
  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL ready_timeout act=0 exp=1");
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [W-1:0] d);
    int busy;
    wait_ready();
    model_step(op, d, busy);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk);
    #1;
    if (busy > 0) begin
      // Keep offering a junk PUSH while busy; it must be ignored.
      cmd_op   = OP_PUSH;
      cmd_data = W'($urandom);
      repeat (2) @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    wait_ready();
    check("count_tos", {count, tos}, {m_cnt(), m_tos()});
  endtask

  task automatic drain();
    while (stk.size() > 0) issue(OP_POP, '0);
  endtask

  initial begin
    int r;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_tos", tos, 0);
    check("rst_result", result, 0);
    check("rst_cond", cond, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_pulses", {res_valid, err_ovf, err_unf, err_div0, err_ill}, 0);
    reset = 1'b1;
    #1 check("ready_low_after_release", cmd_ready, 0);

    issue(OP_PUSH, 16'd4);
    issue(OP_PUSH, 16'd2);
    issue(OP_SUB, '0);
    drain();
    issue(OP_PUSH, 16'd7);
    issue(OP_PUSH, 16'd0);
    issue(OP_DIV, '0);
    drain();
    issue(OP_PUSH, 16'd5);
    issue(OP_PUSH, 16'd5);
    issue(OP_IF_EQ, '0);
    issue(OP_PUSH, 16'd3);
    issue(OP_PUSH, 16'd9);
    issue(OP_IF_GT, '0);
    drain();
    for (int i = 0; i < D; i++) issue(OP_PUSH, 16'h1111);
    issue(OP_PUSH, 16'h2222);
    drain();
    issue(OP_ADD, '0);
    issue(5'd20, '0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      issue(OP_PUSH, W'($urandom));
      else if (r < 42) issue(OP_POP, W'($urandom));
      else if (r < 90) issue(5'($urandom_range(0, 17)), W'($urandom));
      else             issue(5'($urandom_range(18, 31)), W'($urandom));
    end

    // reset in EXEC aborts a NOT
    drain();
    issue(OP_PUSH, 16'h00F0);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = OP_NOT;
    cmd_data  = '0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("in_exec", dbg_state, ST_EXEC);
    reset = 1'b0;
    #1;
    check("abort_count", count, 0);
    check("abort_ready", cmd_ready, 0);
    check("abort_pulses", {res_valid, err_div0}, 0);
    stk.delete();
    m_result = '0;
    m_cond   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1 check("abort_ready_release", cmd_ready, 0);
    @(negedge clk);
    check("abort_ready_up", cmd_ready, 1);
    check("abort_state", {count, tos, result}, 0);
    issue(OP_PUSH, 16'h0123);
    issue(OP_NOT, '0);

    repeat (6) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/stack_alu_engine.md
STACK_ALU_ENGINE -- requirements
Module: stack_alu_engine

Interface
REQ-001 Parameter WIDTH, default 16, data word and operand width in bits (minimum 4).
REQ-002 Parameter DEPTH, default 16, number of stack entries (power of two, minimum 2).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  engine can accept a command (high only in IDLE).
REQ-007 cmd_op  input  5  opcode, encoded per the shared package.
REQ-008 cmd_data  input  WIDTH  operand for PUSH; ignored for all other opcodes.
REQ-009 tos  output  WIDTH  current top of stack; 0 when the stack is empty.
REQ-010 count  output  clog2(DEPTH)+1  number of occupied entries.
REQ-011 res_valid  output  1  one-cycle pulse when an ALU or IF operation completes.
REQ-012 result  output  WIDTH  last ALU result; held until the next completion.
REQ-013 cond  output  1  last IF_xx outcome; held until the next IF_xx completion.
REQ-014 err_ovf, err_unf, err_div0, err_ill  output  1 each  one-cycle error pulses.

Function
REQ-015 Handshake: a command is accepted when cmd_valid and cmd_ready are both high on a rising edge; cmd_op and cmd_data are captured at acceptance.
REQ-016 Opcodes are NOP 0, PUSH 1, POP 2, ADD 3, SUB 4, MUL 5, DIV 6, AND 7, NAND 8, OR 9, XOR 10, CMP 11, NOT 12, IF_EQ 13, IF_GT 14, IF_LT 15, IF_GE 16, IF_LE 17; opcodes 18-31 raise err_ill and change nothing.
REQ-017 FSM states: IDLE, POP_A, POP_B, EXEC, WB.
REQ-018 NOP, PUSH and POP complete within the accept cycle, and the FSM stays in IDLE.
REQ-019 Binary ops and IF_xx follow IDLE -> POP_B -> POP_A -> EXEC -> WB -> IDLE.
  - POP_B loads temp2 with the top entry (op2).
  - POP_A loads temp1 with the next entry (op1).
REQ-020 NOT follows IDLE -> POP_A -> EXEC -> WB -> IDLE, with op1 taken from the top entry.
REQ-021 res_valid asserts in the WB cycle, which is the 4th cycle after acceptance for binary ops and IF_xx, and the 3rd for NOT.
REQ-022 cmd_ready is low from the cycle after acceptance through WB, and high again in the following cycle.
REQ-023 Results are truncated to WIDTH bits and computed unsigned:
  - ADD: op1+op2; SUB: op1-op2; MUL: the low WIDTH bits of op1*op2.
  - DIV: op1/op2.
  - AND, NAND, OR, XOR: bitwise; NOT: ~op1.
  - CMP: 0 if equal, 1 if op1>op2, all-ones if op1<op2.
REQ-024 In WB, ALU ops push the result.
REQ-025 In WB, IF_xx ops set cond per op1 ?= op2, push nothing, and leave result unchanged.
REQ-026 DIV with op2=0: result is all-ones, it is pushed, and err_div0 pulses in WB.
REQ-027 Underflow: PUSH needs 0 operands, POP and NOT need 1, binary ops and IF_xx need 2. If count is below the need at acceptance, err_unf pulses, the stack is unchanged and no res_valid is produced.
REQ-028 Overflow: PUSH with count=DEPTH pulses err_ovf and leaves the stack unchanged. Binary ops never overflow.
REQ-029 Stack pointer wraps modulo DEPTH internally; count saturates at 0 and DEPTH.
REQ-030 cmd_valid with cmd_ready low has no effect, and the command is not queued.

Reset
REQ-031 While reset is low:
  - FSM is in IDLE; count, tos, result, cond, temp1 and temp2 are 0.
  - All error pulses and res_valid are 0; cmd_ready is 0.
REQ-032 Reset asserted mid-operation aborts the operation with no push and no pulses.
REQ-033 Stack storage contents need not be cleared on reset; they are unreachable because count is 0.
REQ-034 cmd_ready rises on the first clock edge after reset deasserts.

Structure
REQ-035 The shared package holds the opcode constants, the FSM state enum, and a function returning the required operand count per opcode.
REQ-036 One sub-module, stack_alu_ula: combinational, WIDTH-parametrised, producing result, cond and div0 from op, op1 and op2.
REQ-037 Stack storage, pointer, FSM and temp registers live in stack_alu_engine.

Verification
REQ-038 PUSH 4, PUSH 2, SUB -> res_valid 4 cycles after acceptance, result=0x0002, count=1, tos=0x0002.
REQ-039 PUSH 7, PUSH 0, DIV -> result=0xFFFF, err_div0 pulse, count=1.
REQ-040 PUSH 5, PUSH 5, IF_EQ -> cond=1, count=0, result unchanged. Then PUSH 3, PUSH 9, IF_GT -> cond=0.
REQ-041 DEPTH pushes of 0x1111, then PUSH 0x2222 -> err_ovf pulse, count=DEPTH, tos=0x1111.
REQ-042 Empty stack, ADD -> err_unf, no res_valid. Then opcode 20 -> err_ill pulse.
REQ-043 PUSH 0x00F0, NOT, with reset asserted in EXEC -> count=0, no res_valid, cmd_ready high one edge after release.
